pipe_stall_ctrl: RTL and testbench
==================================

Name: pipe_stall_ctrl

Overview:
- Hazard and stall controller for the 5-stage pipeline.
- It is the producer of the write enable consumed by the program-counter register and the IF/ID register.
- It detects load-use hazards and holds the front end while the multi-cycle multiply/divide unit (MDU) is busy. While holding, it inserts bubbles into ID/EX.
- It keeps a saturating stall-cycle counter for performance debug.

Parameters:
- MDU_LAT, 4, total MDU latency in cycles including the issue cycle; legal range 1..255.
- CNT_W, 16, width of the stall performance counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- clrn  in  1  asynchronous active-low reset.
- rs  in  5  ID-stage source register 1 number.
- rt  in  5  ID-stage source register 2 number.
- use_rs  in  1  ID instruction reads rs.
- use_rt  in  1  ID instruction reads rt.
- ewreg  in  1  EX-stage instruction writes the register file.
- em2reg  in  1  EX-stage instruction is a load.
- ern  in  5  EX-stage destination register number.
- id_mdu  in  1  ID instruction is a multi-cycle MDU operation.
- wpcir  out  1  write enable for the PC and IF/ID registers (1 = advance, 0 = hold).
- bubble  out  1  zero the ID/EX control fields this cycle.
- mdu_busy  out  1  MDU occupied; controller is in state BUSY.
- stall_cnt  out  CNT_W  saturating count of cycles with wpcir=0.

Behaviour:
- Reset: clk is the single clock. clrn is asynchronous and active-low. Reset forces state RUN, the internal latency counter to 0, stall_cnt to 0 and mdu_busy to 0.
- Outputs out of reset: wpcir=1 and bubble=0, unless a load-use hazard is present on the inputs.
- Load-use hazard (lu), combinational: lu = ewreg & em2reg & (ern != 0) & ((use_rs & ern==rs) | (use_rt & ern==rt)).
- A register number of 0 never causes a hazard.
- State RUN:
  - lu=1: wpcir=0, bubble=1, state stays RUN. The load advances, so the hazard clears next cycle: exactly 1 stall cycle.
  - lu=0 and id_mdu=1: the MDU op issues this cycle (wpcir=1, bubble=0). If MDU_LAT>1, go to BUSY and load the counter with MDU_LAT-2. If MDU_LAT=1, stay in RUN.
  - Otherwise: wpcir=1, bubble=0.
- State BUSY:
  - wpcir=0, bubble=1, mdu_busy=1. id_mdu and lu are ignored.
  - Counter==0: go to RUN next edge. Otherwise decrement.
  - BUSY therefore lasts exactly MDU_LAT-1 cycles.
- Simultaneous lu and id_mdu in RUN: lu wins. The MDU op is held in ID and issues on the following cycle, when lu=0.
- Back-to-back MDU ops: the second op is held in ID during BUSY and issues in the first RUN cycle after BUSY.
- stall_cnt: increments on each rising edge where wpcir=0. It holds at 2^CNT_W-1 and never wraps.
- mdu_busy is registered (equals state==BUSY). wpcir and bubble are combinational from state and inputs, with no registered latency.
- Reset mid-BUSY: returns to RUN immediately, wpcir=1 and the counter is cleared. No stall completion is owed after reset.
- Invariant: bubble == ~wpcir in every cycle.

Test Plan:
- Reset: clrn=0 with no hazard inputs -> wpcir=1, bubble=0, mdu_busy=0, stall_cnt=0. Release clrn; idle 5 cycles -> outputs unchanged.
- Load-use on rs: ewreg=1, em2reg=1, ern=5, rs=5, use_rs=1 for one cycle -> wpcir=0 and bubble=1 for 1 cycle, stall_cnt=1.
- Load-use variants:
  - ern=0 -> no stall.
  - use_rt=0 with ern==rt -> no stall.
  - ewreg=1, em2reg=0 -> no stall.
- MDU issue with MDU_LAT=4: id_mdu=1 at cycle t -> wpcir=1 at t; wpcir=0 and mdu_busy=1 for t+1..t+3; wpcir=1 at t+4; stall_cnt=3.
- Priority: lu=1 and id_mdu=1 together -> 1 stall cycle, then MDU issue, then 3 BUSY cycles; stall_cnt=4. Back-to-back id_mdu -> second issue at t+4.
- Reset mid-BUSY: assert clrn=0 at t+2 -> mdu_busy=0 and wpcir=1 asynchronously. With CNT_W=4, 20 stall cycles -> stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipe_stall_ctrl.sv
// Hazard/stall controller: load-use detection, MDU busy hold,
// and a saturating stall-cycle counter for perf debug.
module pipe_stall_ctrl #(
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             use_rs,
  input  logic             use_rt,
  input  logic             ewreg,
  input  logic             em2reg,
  input  logic [4:0]       ern,
  input  logic             id_mdu,
  output logic             wpcir,
  output logic             bubble,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [7:0] LOAD =
    (MDU_LAT > 1) ? 8'(MDU_LAT - 2) : 8'd0;
  localparam logic       MULTI = (MDU_LAT > 1);

  state_t     state, state_n;
  logic [7:0] lat, lat_n;
  logic       lu;

  // load-use: EX load targets a register ID is about to read
  always_comb begin
    lu = ewreg & em2reg & (ern != 5'd0) &
         ((use_rs & (ern == rs)) | (use_rt & (ern == rt)));
  end

  // next state, latency count and front-end hold
  always_comb begin
    state_n = state;
    lat_n   = lat;
    wpcir   = 1'b1;
    bubble  = 1'b0;
    unique case (state)
      RUN: begin
        if (lu) begin
          wpcir  = 1'b0;
          bubble = 1'b1;
        end else if (id_mdu && MULTI) begin
          state_n = BUSY;
          lat_n   = LOAD;
        end
      end
      BUSY: begin
        wpcir  = 1'b0;
        bubble = 1'b1;
        if (lat == 8'd0) state_n = RUN;
        else             lat_n   = lat - 8'd1;
      end
      default: state_n = RUN;
    endcase
  end

  // state and latency registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= RUN;
      lat   <= 8'd0;
    end else begin
      state <= state_n;
      lat   <= lat_n;
    end
  end

  // busy flag is simply the registered state
  always_comb begin
    mdu_busy = (state == BUSY);
  end

  // saturating count of held cycles
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn)
      stall_cnt <= '0;
    else if (!wpcir && (stall_cnt != '1))
      stall_cnt <= stall_cnt + CNT_W'(1);
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: hazards, MDU hold,
// priority, async reset and counter saturation.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        clrn;
  logic [4:0]  rs, rt, ern;
  logic        use_rs, use_rt, ewreg, em2reg, id_mdu;
  logic        wpcir, bubble, mdu_busy;
  logic [15:0] stall_cnt;
  logic        wpcir4, bubble4, busy4;
  logic [3:0]  cnt4;

  int nrun  = 0;
  int nfail = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.MDU_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .ewreg(ewreg),
    .em2reg(em2reg), .ern(ern), .id_mdu(id_mdu),
    .wpcir(wpcir), .bubble(bubble), .mdu_busy(mdu_busy),
    .stall_cnt(stall_cnt)
  );

  pipe_stall_ctrl #(.MDU_LAT(4), .CNT_W(4)) dut4 (
    .clk(clk), .clrn(clrn), .rs(rs), .rt(rt),
    .use_rs(use_rs), .use_rt(use_rt), .ewreg(ewreg),
    .em2reg(em2reg), .ern(ern), .id_mdu(id_mdu),
    .wpcir(wpcir4), .bubble(bubble4), .mdu_busy(busy4),
    .stall_cnt(cnt4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rs = 5'd0; rt = 5'd0; ern = 5'd0;
    use_rs = 1'b0; use_rt = 1'b0;
    ewreg = 1'b0; em2reg = 1'b0; id_mdu = 1'b0;
  endtask

  task automatic load_hit(input logic [4:0] r);
    ewreg = 1'b1; em2reg = 1'b1; ern = r;
    rs = r; use_rs = 1'b1;
  endtask

  task automatic test_reset();
    idle_in();
    clrn = 1'b0;
    #3;
    nrun++;
    if ({wpcir, bubble, mdu_busy} !== 3'b100) begin
      nfail++;
      $display("FAIL reset_out got %b want 100",
               {wpcir, bubble, mdu_busy});
    end
    nrun++;
    if (stall_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL reset_cnt got %0d want 0", stall_cnt);
    end
    tick();
    clrn = 1'b1;
    repeat (5) tick();
    #1;
    nrun++;
    if ({wpcir, bubble, mdu_busy} !== 3'b100 ||
        stall_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL reset_idle got %b cnt %0d want 100 cnt 0",
               {wpcir, bubble, mdu_busy}, stall_cnt);
    end
  endtask

  task automatic test_load_use();
    load_hit(5'd5);
    #1;
    nrun++;
    if ({wpcir, bubble} !== 2'b01) begin
      nfail++;
      $display("FAIL lu_rs got %b want 01", {wpcir, bubble});
    end
    tick();
    exp_cnt++;
    idle_in();
    #1;
    nrun++;
    if (wpcir !== 1'b1 || stall_cnt !== 16'(exp_cnt)) begin
      nfail++;
      $display("FAIL lu_rs_after got w=%b cnt=%0d want w=1 cnt=%0d",
               wpcir, stall_cnt, exp_cnt);
    end
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd9;
    rt = 5'd9; use_rt = 1'b1;
    #1;
    nrun++;
    if ({wpcir, bubble} !== 2'b01) begin
      nfail++;
      $display("FAIL lu_rt got %b want 01", {wpcir, bubble});
    end
    tick();
    exp_cnt++;
    idle_in();
  endtask

  task automatic test_no_hazard();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd0;
    rs = 5'd0; use_rs = 1'b1;
    #1;
    nrun++;
    if ({wpcir, bubble} !== 2'b10) begin
      nfail++;
      $display("FAIL nh_r0 got %b want 10", {wpcir, bubble});
    end
    tick();
    idle_in();
    ewreg = 1'b1; em2reg = 1'b1; ern = 5'd7;
    rt = 5'd7; use_rt = 1'b0; rs = 5'd3; use_rs = 1'b1;
    #1;
    nrun++;
    if ({wpcir, bubble} !== 2'b10) begin
      nfail++;
      $display("FAIL nh_unused got %b want 10", {wpcir, bubble});
    end
    tick();
    idle_in();
    load_hit(5'd12);
    em2reg = 1'b0;
    #1;
    nrun++;
    if ({wpcir, bubble} !== 2'b10) begin
      nfail++;
      $display("FAIL nh_notload got %b want 10", {wpcir, bubble});
    end
    tick();
    idle_in();
    #1;
    nrun++;
    if (stall_cnt !== 16'(exp_cnt)) begin
      nfail++;
      $display("FAIL nh_cnt got %0d want %0d", stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_mdu();
    id_mdu = 1'b1;
    #1;
    nrun++;
    if ({wpcir, bubble, mdu_busy} !== 3'b100) begin
      nfail++;
      $display("FAIL mdu_issue got %b want 100",
               {wpcir, bubble, mdu_busy});
    end
    tick();
    id_mdu = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      #1;
      nrun++;
      if ({wpcir, bubble, mdu_busy} !== 3'b011) begin
        nfail++;
        $display("FAIL mdu_busy_t%0d got %b want 011", k,
                 {wpcir, bubble, mdu_busy});
      end
      tick();
      exp_cnt++;
    end
    #1;
    nrun++;
    if ({wpcir, mdu_busy} !== 2'b10 ||
        stall_cnt !== 16'(exp_cnt)) begin
      nfail++;
      $display("FAIL mdu_done got %b cnt %0d want 10 cnt %0d",
               {wpcir, mdu_busy}, stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_priority();
    int base;
    base = exp_cnt;
    load_hit(5'd4);
    id_mdu = 1'b1;
    #1;
    nrun++;
    if ({wpcir, bubble, mdu_busy} !== 3'b010) begin
      nfail++;
      $display("FAIL pri_lu got %b want 010",
               {wpcir, bubble, mdu_busy});
    end
    tick();
    exp_cnt++;
    ewreg = 1'b0; em2reg = 1'b0;
    #1;
    nrun++;
    if ({wpcir, mdu_busy} !== 2'b10) begin
      nfail++;
      $display("FAIL pri_issue got %b want 10", {wpcir, mdu_busy});
    end
    tick();
    idle_in();
    repeat (3) begin
      tick();
      exp_cnt++;
    end
    #1;
    nrun++;
    if (wpcir !== 1'b1 || stall_cnt !== 16'(base + 4)) begin
      nfail++;
      $display("FAIL pri_cnt got w=%b cnt=%0d want w=1 cnt=%0d",
               wpcir, stall_cnt, base + 4);
    end
  endtask

  task automatic test_back_to_back();
    id_mdu = 1'b1;
    repeat (4) tick();
    exp_cnt += 3;
    #1;
    nrun++;
    if ({wpcir, mdu_busy} !== 2'b10) begin
      nfail++;
      $display("FAIL b2b_second_issue got %b want 10",
               {wpcir, mdu_busy});
    end
    tick();
    id_mdu = 1'b0;
    #1;
    nrun++;
    if ({wpcir, bubble, mdu_busy} !== 3'b011) begin
      nfail++;
      $display("FAIL b2b_busy got %b want 011",
               {wpcir, bubble, mdu_busy});
    end
    repeat (3) tick();
    exp_cnt += 3;
    #1;
    nrun++;
    if (mdu_busy !== 1'b0 || stall_cnt !== 16'(exp_cnt)) begin
      nfail++;
      $display("FAIL b2b_cnt got busy=%b cnt=%0d want 0 cnt=%0d",
               mdu_busy, stall_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid_busy();
    id_mdu = 1'b1;
    tick();
    id_mdu = 1'b0;
    tick();
    #1;
    nrun++;
    if (mdu_busy !== 1'b1) begin
      nfail++;
      $display("FAIL rmb_pre got busy=%b want 1", mdu_busy);
    end
    clrn = 1'b0;
    #1;
    nrun++;
    if ({wpcir, bubble, mdu_busy} !== 3'b100 ||
        stall_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL rmb_async got %b cnt %0d want 100 cnt 0",
               {wpcir, bubble, mdu_busy}, stall_cnt);
    end
    exp_cnt = 0;
    #2;
    clrn = 1'b1;
    repeat (3) tick();
    #1;
    nrun++;
    if ({wpcir, mdu_busy} !== 2'b10 || stall_cnt !== 16'd0) begin
      nfail++;
      $display("FAIL rmb_after got %b cnt %0d want 10 cnt 0",
               {wpcir, mdu_busy}, stall_cnt);
    end
  endtask

  task automatic test_saturate();
    load_hit(5'd20);
    repeat (14) tick();
    #1;
    nrun++;
    if (cnt4 !== 4'd14) begin
      nfail++;
      $display("FAIL sat_14 got %0d want 14", cnt4);
    end
    repeat (6) tick();
    idle_in();
    #1;
    nrun++;
    if (cnt4 !== 4'd15) begin
      nfail++;
      $display("FAIL sat_hold got %0d want 15", cnt4);
    end
    nrun++;
    if (stall_cnt !== 16'd20) begin
      nfail++;
      $display("FAIL sat_wide got %0d want 20", stall_cnt);
    end
    nrun++;
    if (bubble4 !== ~wpcir4 || busy4 !== 1'b0) begin
      nfail++;
      $display("FAIL sat_inv got b=%b w=%b busy=%b want b=~w busy=0",
               bubble4, wpcir4, busy4);
    end
  endtask

  always @(negedge clk) begin
    if (clrn === 1'b1) begin
      nrun++;
      if (bubble !== ~wpcir) begin
        nfail++;
        $display("FAIL invariant got b=%b w=%b want b=~w",
                 bubble, wpcir);
      end
    end
  end

  initial begin
    test_reset();
    test_load_use();
    test_no_hazard();
    test_mdu();
    test_priority();
    test_back_to_back();
    test_reset_mid_busy();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", nrun, nfail);
    $finish;
  end

endmodule
